// File: rtl/example_unit.sv
// example_unit: registered unsigned add/subtract/compare/max-min leaf stage.
// Latency 1 cycle, one result per cycle; no backpressure, so every out_valid pulse must be consumed.
// Ports: clk/rst (async active-high); in_valid, a, b in; out_valid, c=a+b, diff=a-b,
//        a_gt_b/a_eq_b/a_lt_b, max_ab, min_ab out -- all driven straight from flops.
module example_unit #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  output logic [W:0]   c,
  output logic [W:0]   diff,
  output logic         a_gt_b,
  output logic         a_eq_b,
  output logic         a_lt_b,
  output logic [W-1:0] max_ab,
  output logic [W-1:0] min_ab
);

  logic         out_valid_q, out_valid_d;
  logic [W:0]   c_q, c_d;
  logic [W:0]   diff_q, diff_d;
  logic         a_gt_b_q, a_gt_b_d;
  logic         a_eq_b_q, a_eq_b_d;
  logic         a_lt_b_q, a_lt_b_d;
  logic [W-1:0] max_ab_q, max_ab_d;
  logic [W-1:0] min_ab_q, min_ab_d;

  logic [W:0]   a_ext;
  logic [W:0]   b_ext;
  logic [W:0]   sub;

  assign a_ext = {1'b0, a};
  assign b_ext = {1'b0, b};
  // With zero-extended operands the MSB of the (W+1)-bit difference is the
  // borrow, so it doubles as the a<b flag.
  assign sub   = a_ext - b_ext;

  always_comb begin
    out_valid_d = in_valid;
    // Data outputs hold while idle; the hold mux also keeps unknown operands
    // presented with in_valid low from reaching the flops.
    c_d      = c_q;
    diff_d   = diff_q;
    a_gt_b_d = a_gt_b_q;
    a_eq_b_d = a_eq_b_q;
    a_lt_b_d = a_lt_b_q;
    max_ab_d = max_ab_q;
    min_ab_d = min_ab_q;
    if (in_valid) begin
      c_d      = a_ext + b_ext;
      diff_d   = sub;
      a_lt_b_d = sub[W];
      a_eq_b_d = (a == b);
      a_gt_b_d = !sub[W] && (a != b);
      max_ab_d = sub[W] ? b : a;
      min_ab_d = sub[W] ? a : b;
    end
  end

  // Reset values correspond to a=b=0, hence a_eq_b resets to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      c_q         <= '0;
      diff_q      <= '0;
      a_gt_b_q    <= 1'b0;
      a_eq_b_q    <= 1'b1;
      a_lt_b_q    <= 1'b0;
      max_ab_q    <= '0;
      min_ab_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      c_q         <= c_d;
      diff_q      <= diff_d;
      a_gt_b_q    <= a_gt_b_d;
      a_eq_b_q    <= a_eq_b_d;
      a_lt_b_q    <= a_lt_b_d;
      max_ab_q    <= max_ab_d;
      min_ab_q    <= min_ab_d;
    end
  end

  assign out_valid = out_valid_q;
  assign c         = c_q;
  assign diff      = diff_q;
  assign a_gt_b    = a_gt_b_q;
  assign a_eq_b    = a_eq_b_q;
  assign a_lt_b    = a_lt_b_q;
  assign max_ab    = max_ab_q;
  assign min_ab    = min_ab_q;

endmodule

// File: tb/tb_example_unit.sv
// Bench for example_unit (W=8): directed vector table, async-reset sequences,
// and randomized traffic checked against an arithmetic reference model.
module tb_example_unit;
  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic [W:0]   c;
  logic [W:0]   diff;
  logic         a_gt_b;
  logic         a_eq_b;
  logic         a_lt_b;
  logic [W-1:0] max_ab;
  logic [W-1:0] min_ab;

  example_unit #(.W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b),
    .out_valid(out_valid), .c(c), .diff(diff),
    .a_gt_b(a_gt_b), .a_eq_b(a_eq_b), .a_lt_b(a_lt_b),
    .max_ab(max_ab), .min_ab(min_ab)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int ov; int c; int diff; int gt; int eq; int lt; int mx; int mn;
  } exp_t;

  typedef struct {
    int   v; int a; int b;
    exp_t e;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv)
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    else
      n_pass++;
  endtask

  task automatic chk_all(input string tag, input exp_t e);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(e.ov));
    chk({tag, ".c"},         32'(c),         32'(e.c));
    chk({tag, ".diff"},      32'(diff),      32'(e.diff));
    chk({tag, ".a_gt_b"},    32'(a_gt_b),    32'(e.gt));
    chk({tag, ".a_eq_b"},    32'(a_eq_b),    32'(e.eq));
    chk({tag, ".a_lt_b"},    32'(a_lt_b),    32'(e.lt));
    chk({tag, ".max_ab"},    32'(max_ab),    32'(e.mx));
    chk({tag, ".min_ab"},    32'(min_ab),    32'(e.mn));
  endtask

  // Reference: plain integer arithmetic; difference wrapped to W+1 bits.
  function automatic exp_t ref_op(input int x, input int y);
    exp_t r;
    r.ov   = 1;
    r.c    = x + y;
    r.diff = (x - y) & ((1 << (W + 1)) - 1);
    r.gt   = (x > y) ? 1 : 0;
    r.eq   = (x == y) ? 1 : 0;
    r.lt   = (x < y) ? 1 : 0;
    r.mx   = (x > y) ? x : y;
    r.mn   = (x < y) ? x : y;
    return r;
  endfunction

  exp_t rst_exp;
  exp_t m;
  vec_t vec[$];

  initial begin
    rst_exp = '{0, 0, 0, 0, 1, 0, 0, 0};

    // Hand-computed expectations (W=8, diff is 9 bits).
    vec.push_back('{1, 1, 2,     '{1, 3,   'h1FF, 0, 0, 1, 2,   1}});
    vec.push_back('{1, 1, 1,     '{1, 2,   'h000, 0, 1, 0, 1,   1}});
    vec.push_back('{1, 2, 3,     '{1, 5,   'h1FF, 0, 0, 1, 3,   2}});
    vec.push_back('{1, 3, 2,     '{1, 5,   'h001, 1, 0, 0, 3,   2}});
    vec.push_back('{1, 4, 2,     '{1, 6,   'h002, 1, 0, 0, 4,   2}});
    vec.push_back('{1, 2, 4,     '{1, 6,   'h1FE, 0, 0, 1, 4,   2}});
    vec.push_back('{1, 5, 3,     '{1, 8,   'h002, 1, 0, 0, 5,   3}});
    vec.push_back('{1, 4, 1,     '{1, 5,   'h003, 1, 0, 0, 4,   1}});
    vec.push_back('{1, 255, 255, '{1, 510, 'h000, 0, 1, 0, 255, 255}});
    vec.push_back('{1, 5, 3,     '{1, 8,   'h002, 1, 0, 0, 5,   3}});
    vec.push_back('{0, 7, 9,     '{0, 8,   'h002, 1, 0, 0, 5,   3}});
    vec.push_back('{0, 0, 200,   '{0, 8,   'h002, 1, 0, 0, 5,   3}});
    vec.push_back('{1, 0, 0,     '{1, 0,   'h000, 0, 1, 0, 0,   0}});
    vec.push_back('{1, 0, 255,   '{1, 255, 'h101, 0, 0, 1, 255, 0}});
    vec.push_back('{1, 255, 0,   '{1, 255, 'h0FF, 1, 0, 0, 255, 0}});

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0;
    #12;
    chk_all("reset_initial", rst_exp);
    @(negedge clk);
    rst = 1'b0;

    // Directed table: drive on one falling edge, check on the next.
    for (int i = 0; i < vec.size(); i++) begin
      in_valid = vec[i].v[0];
      a = W'(vec[i].a);
      b = W'(vec[i].b);
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), vec[i].e);
    end

    // Asynchronous reset mid-cycle, no clock edge between assert and check.
    in_valid = 1'b1; a = 8'd9; b = 8'd4;
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_all("async_rst", rst_exp);
    @(negedge clk);
    chk_all("rst_held", rst_exp);
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk_all("post_rst_idle", rst_exp);

    // Reset pulse between valid inputs discards the in-flight result.
    in_valid = 1'b1; a = 8'd5; b = 8'd3;
    @(negedge clk);
    chk_all("stream_pre", ref_op(5, 3));
    a = 8'd2; b = 8'd2;
    @(posedge clk);
    #2 rst = 1'b1; in_valid = 1'b0;
    #2 rst = 1'b0;
    @(negedge clk);
    chk_all("stream_rst", rst_exp);
    in_valid = 1'b1; a = 8'd4; b = 8'd1;
    @(negedge clk);
    chk_all("stream_after_rst", ref_op(4, 1));

    // Unknown operands while idle must not disturb held outputs.
    a = 8'd7; b = 8'd7;
    @(negedge clk);
    m = ref_op(7, 7);
    chk_all("x_pre", m);
    in_valid = 1'b0; a = 'x; b = 'x;
    m.ov = 0;
    repeat (2) begin
      @(negedge clk);
      chk_all("x_hold", m);
    end

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      int rv, ra, rb;
      rv = ($urandom_range(0, 9) < 7) ? 1 : 0;
      ra = $urandom_range(0, (1 << W) - 1);
      rb = (($urandom_range(0, 7)) == 0) ? ra : $urandom_range(0, (1 << W) - 1);
      in_valid = rv[0];
      a = W'(ra);
      b = W'(rb);
      if (rv == 1) m = ref_op(ra, rb);
      else         m.ov = 0;
      @(negedge clk);
      chk_all($sformatf("rand%0d", i), m);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
